sync_mux_rr: RTL and testbench
==============================

# sync_mux_rr

Parametrised, registered N:1 datapath multiplexer with per-channel valid/ready handshakes, one output register stage, and either externally selected or round-robin channel choice. It supersedes the fixed 32-bit two-input combinational mux wherever several producers (ALU result, memory load, PC+4, immediate, forwarding paths) compete for one downstream consumer that can stall. The output register cuts the select-to-consumer combinational path at the cost of one cycle of latency.

## Interface
- WIDTH, 32, data width per channel (≥1)
- N, 2, number of input channels (≥2)
- MODE, 0, 0 = select by `sel`; 1 = round-robin among valid channels
- SELW, derived = max(1, clog2(N)); not overridden by instantiators
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i presents a word
- in_ready  output  N  channel i word is accepted this cycle (combinational)
- sel  input  SELW  requested channel, MODE=0 only; ignored in MODE=1
- out_data  output  WIDTH  registered selected word
- out_chan  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_chan hold a word
- out_ready  input  1  consumer accepts the word this cycle

## Operation
- Load enable: `ld = ~out_valid | out_ready` (register empty or draining this cycle).
- Grant, MODE=0: channel g = sel if sel < N and in_valid[sel]; otherwise no grant. Valid on other channels is ignored.
- Grant, MODE=1: g = first i with in_valid[i], scanning ptr, ptr+1, …, N-1, 0, …, ptr-1; no grant if no valid.
- in_ready[i] = rst_n & ld & grant & (g == i); at most one bit set per cycle.
- Transfer (in_ready[g] & in_valid[g]): out_data ← in_data[g], out_chan ← g, out_valid ← 1; MODE=1: ptr ← (g+1) mod N, wrapping at N-1 → 0.
- ld with no grant: out_valid ← 0; out_data/out_chan hold their last values.
- ~ld (out_valid & ~out_ready): out_data, out_chan, out_valid hold; no in_ready asserted; ptr holds.
- ptr is internal, SELW bits, only changes on transfer; unused in MODE=0.
- Reset (rst_n=0 at edge): out_valid=0, out_data=0, out_chan=0, ptr=0; while rst_n=0, in_ready=0 regardless of inputs. Reset mid-transfer discards the held word; no input is accepted in the reset cycle.
- Producers must hold in_data/in_valid until in_ready; the block does not depend on that for correctness, but data not accepted is not captured.

## Timing
- Latency: word accepted at edge k appears on out_data with out_valid=1 after edge k (visible in cycle k+1).
- Throughput: one word per cycle when out_ready=1 continuously (simultaneous drain and load in the same cycle).
- Combinational paths: in_valid, sel, out_ready, out_valid → in_ready only; no input-to-output combinational path on out_data/out_chan/out_valid.
- Back-pressure: out_ready=0 with out_valid=1 deasserts all in_ready in the same cycle.
- Round-robin fairness: with all N channels valid continuously and out_ready=1, each channel is granted exactly once every N cycles.

## Test plan
- Reset: rst_n=0 for 2 cycles with all in_valid=1, out_ready=1 → in_ready=0, out_valid=0, out_data=0, out_chan=0; first grant after release goes to channel 0 (MODE=1).
- MODE=0, N=4, WIDTH=32: sel=2, in_data ch2=0xDEADBEEF, in_valid=4'b0100 → in_ready=4'b0100, next cycle out_data=0xDEADBEEF, out_chan=2; sel=3 with in_valid[3]=0 → no in_ready, out_valid drops to 0 after drain.
- MODE=1, N=4, all valid, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3; one in_ready bit per cycle.
- MODE=1 wrap/skip: ptr=3, in_valid=4'b0101 → grant ch0, then ptr=1 → grant ch2, then ch0.
- Back-pressure: out_valid=1 with out_data=0x00000011, out_ready=0 for 3 cycles while inputs change → out_data/out_chan stable, in_ready=0; out_ready=1 → new word loaded same cycle, out_valid stays 1.
- Reset mid-stream: rst_n=0 one cycle while out_valid=1 and out_ready=0 → out_valid=0, out_data=0 next cycle, ptr=0.

Source files
------------

// File: rtl/sync_mux_rr.sv
// sync_mux_rr: registered N:1 datapath multiplexer with valid/ready handshakes.
//
// Several producers share one downstream consumer. One channel is granted per
// cycle, either by the external `sel` (MODE=0) or round-robin among the valid
// channels (MODE=1). The granted word goes into a single output register, so
// nothing combinational runs from the inputs to out_data/out_chan/out_valid.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    N*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   N, per-channel word present
//   in_ready   N, per-channel word accepted this cycle (combinational)
//   sel        SELW, requested channel (MODE=0 only)
//   out_data   WIDTH, registered word
//   out_chan   SELW, channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer takes the word this cycle

module sync_mux_rr #(
    parameter  int WIDTH = 32,
    parameter  int N     = 2,
    parameter  int MODE  = 0,
    localparam int SELW  = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic                        ld;       // output register may take a new word
    logic                        grant;
    logic [SELW-1:0]             g;
    logic [SELW-1:0]             ptr;      // round-robin start position
    logic                        en;
    logic [N-1:0][WIDTH-1:0]     masked;
    logic [WIDTH-1:0]            sel_word;
    int                          idx;

    assign ld = ~out_valid | out_ready;
    assign en = rst_n & ld & grant;

    // Grant selection. In round-robin mode the scan starts at ptr and wraps,
    // so the channel just served drops to lowest priority.
    always_comb begin
        grant = 1'b0;
        g     = '0;
        idx   = 0;
        if (MODE == 1) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!grant && in_valid[SELW'(idx)]) begin
                    grant = 1'b1;
                    g     = SELW'(idx);
                end
            end
        end else begin
            g = sel;
            if (int'(sel) < N) grant = in_valid[sel];
        end
    end

    // Per-channel ready decode and data masking; the mux is an AND-OR tree
    // so at most one lane contributes a non-zero word.
    for (genvar i = 0; i < N; i++) begin : g_lane
        sync_mux_rr_lane #(
            .WIDTH (WIDTH),
            .SELW  (SELW),
            .IDX   (i)
        ) u_lane (
            .en          (en),
            .g           (g),
            .data        (in_data[i*WIDTH +: WIDTH]),
            .ready       (in_ready[i]),
            .data_masked (masked[i])
        );
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) sel_word = sel_word | masked[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (ld) begin
            if (grant) begin
                out_data  <= sel_word;
                out_chan  <= g;
                out_valid <= 1'b1;
                ptr       <= (g == SELW'(N - 1)) ? '0 : g + 1'b1;
            end else begin
                // Drained with nothing to replace it: data/chan keep last word.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// One channel's slice: ready decode and gated data contribution.
module sync_mux_rr_lane #(
    parameter int WIDTH = 32,
    parameter int SELW  = 1,
    parameter int IDX   = 0
) (
    input  logic              en,
    input  logic [SELW-1:0]   g,
    input  logic [WIDTH-1:0]  data,
    output logic              ready,
    output logic [WIDTH-1:0]  data_masked
);

    assign ready       = en & (g == SELW'(IDX));
    assign data_masked = ready ? data : '0;

endmodule

// File: tb/tb_sync_mux_rr.sv
module tb_sync_mux_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // u0: MODE=0 (select), u1: MODE=1 (round-robin); both N=4, WIDTH=32
    logic [3:0][31:0] d0, d1;
    logic [3:0]       v0, v1, r0, r1;
    logic [1:0]       sel0, sel1;
    logic [31:0]      od0, od1;
    logic [1:0]       oc0, oc1;
    logic             ov0, ov1, ordy0, ordy1;

    int errors = 0;
    int checks = 0;

    sync_mux_rr #(.WIDTH(32), .N(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(r0),
        .sel(sel0), .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(ordy0)
    );

    sync_mux_rr #(.WIDTH(32), .N(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .sel(sel1), .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(ordy1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        v0 = 4'hF; v1 = 4'hF; ordy0 = 1'b1; ordy1 = 1'b1; sel0 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            d0[i] = 32'h100 + i; d1[i] = 32'h200 + i;
        end
        tick; tick;
        #1;
        checks++; if (r0 !== 4'b0000) begin errors++; $display("FAIL rst_ready0: got %b want 0000", r0); end
        checks++; if (r1 !== 4'b0000) begin errors++; $display("FAIL rst_ready1: got %b want 0000", r1); end
        checks++; if ({ov0, ov1} !== 2'b00) begin errors++; $display("FAIL rst_valid: got %b want 00", {ov0, ov1}); end
        checks++; if (od1 !== 32'h0 || oc1 !== 2'd0) begin errors++; $display("FAIL rst_data1: got %h/%0d want 0/0", od1, oc1); end
        checks++; if (od0 !== 32'h0 || oc0 !== 2'd0) begin errors++; $display("FAIL rst_data0: got %h/%0d want 0/0", od0, oc0); end
        rst_n = 1'b1;
        #1;
        checks++; if (r1 !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b want 0001", r1); end
        tick;
        checks++; if (ov1 !== 1'b1 || oc1 !== 2'd0 || od1 !== 32'h200) begin
            errors++; $display("FAIL rst_first_word: got v=%b c=%0d d=%h want 1/0/200", ov1, oc1, od1); end
        v0 = 4'h0; v1 = 4'h0;
        tick;   // both drain, u1 ptr=1
        checks++; if ({ov0, ov1} !== 2'b00) begin errors++; $display("FAIL rst_drain: got %b want 00", {ov0, ov1}); end
    endtask

    task automatic test_sel;
        sel0 = 2'd2; d0[2] = 32'hDEADBEEF; v0 = 4'b0100; ordy0 = 1'b1;
        #1;
        checks++; if (r0 !== 4'b0100) begin errors++; $display("FAIL sel_ready: got %b want 0100", r0); end
        tick;
        checks++; if (od0 !== 32'hDEADBEEF || oc0 !== 2'd2 || ov0 !== 1'b1) begin
            errors++; $display("FAIL sel_word: got %h/%0d/%b want deadbeef/2/1", od0, oc0, ov0); end
        sel0 = 2'd3; v0 = 4'b0111;   // other channels valid, selected one not
        #1;
        checks++; if (r0 !== 4'b0000) begin errors++; $display("FAIL sel_invalid_ready: got %b want 0000", r0); end
        tick;
        checks++; if (ov0 !== 1'b0 || od0 !== 32'hDEADBEEF || oc0 !== 2'd2) begin
            errors++; $display("FAIL sel_drain: got %b/%h/%0d want 0/deadbeef/2", ov0, od0, oc0); end
        v0 = 4'h0;
    endtask

    task automatic test_round_robin;
        rst_n = 1'b0; tick; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) d1[i] = 32'hA0 + i;
        v1 = 4'hF; ordy1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (r1 !== (4'b0001 << (c % 4))) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b want %b", c, r1, 4'b0001 << (c % 4)); end
            tick;
            checks++; if (oc1 !== 2'(c % 4) || od1 !== 32'hA0 + (c % 4) || ov1 !== 1'b1) begin
                errors++; $display("FAIL rr_out[%0d]: got %0d/%h want %0d/%h", c, oc1, od1, c % 4, 32'hA0 + (c % 4)); end
        end
    endtask

    task automatic test_wrap_skip;
        // ptr=0 here; three grants move it to 3
        tick; tick; tick;
        checks++; if (oc1 !== 2'd2) begin errors++; $display("FAIL ws_setup: got %0d want 2", oc1); end
        v1 = 4'b0101;
        #1;
        checks++; if (r1 !== 4'b0001) begin errors++; $display("FAIL ws_wrap_ready: got %b want 0001", r1); end
        tick;
        checks++; if (oc1 !== 2'd0) begin errors++; $display("FAIL ws_wrap_chan: got %0d want 0", oc1); end
        #1;
        checks++; if (r1 !== 4'b0100) begin errors++; $display("FAIL ws_skip_ready: got %b want 0100", r1); end
        tick;
        checks++; if (oc1 !== 2'd2 || od1 !== 32'hA2) begin errors++; $display("FAIL ws_skip_chan: got %0d/%h want 2/a2", oc1, od1); end
        tick;
        checks++; if (oc1 !== 2'd0 || od1 !== 32'hA0) begin errors++; $display("FAIL ws_back_chan: got %0d/%h want 0/a0", oc1, od1); end
        v1 = 4'h0;
        tick;   // drain, ptr=1
    endtask

    task automatic test_back_pressure;
        sel0 = 2'd1; d0[1] = 32'h11; v0 = 4'b0010; ordy0 = 1'b1;
        tick;
        checks++; if (od0 !== 32'h11 || oc0 !== 2'd1 || ov0 !== 1'b1) begin
            errors++; $display("FAIL bp_load: got %h/%0d/%b want 11/1/1", od0, oc0, ov0); end
        ordy0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sel0 = 2'(c); d0[c] = 32'h22 + c; v0 = 4'hF;
            #1;
            checks++; if (r0 !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, r0); end
            tick;
            checks++; if (od0 !== 32'h11 || oc0 !== 2'd1 || ov0 !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b want 11/1/1", c, od0, oc0, ov0); end
        end
        sel0 = 2'd3; d0[3] = 32'h77; ordy0 = 1'b1;
        #1;
        checks++; if (r0 !== 4'b1000) begin errors++; $display("FAIL bp_release_ready: got %b want 1000", r0); end
        tick;
        checks++; if (od0 !== 32'h77 || oc0 !== 2'd3 || ov0 !== 1'b1) begin
            errors++; $display("FAIL bp_release_word: got %h/%0d/%b want 77/3/1", od0, oc0, ov0); end
        v0 = 4'h0;
        tick;
    endtask

    task automatic test_reset_mid;
        d1[2] = 32'h5A5A; v1 = 4'b0100; ordy1 = 1'b1;
        tick;   // ch2 taken, ptr=3
        checks++; if (oc1 !== 2'd2 || ov1 !== 1'b1) begin errors++; $display("FAIL rm_load: got %0d/%b want 2/1", oc1, ov1); end
        ordy1 = 1'b0; v1 = 4'hF;
        rst_n = 1'b0;
        #1;
        checks++; if (r1 !== 4'b0000) begin errors++; $display("FAIL rm_ready: got %b want 0000", r1); end
        tick;
        checks++; if (ov1 !== 1'b0 || od1 !== 32'h0 || oc1 !== 2'd0) begin
            errors++; $display("FAIL rm_clear: got %b/%h/%0d want 0/0/0", ov1, od1, oc1); end
        rst_n = 1'b1; ordy1 = 1'b1;
        #1;
        checks++; if (r1 !== 4'b0001) begin errors++; $display("FAIL rm_ptr: got %b want 0001", r1); end
        tick;
        checks++; if (oc1 !== 2'd0 || od1 !== 32'hA0) begin errors++; $display("FAIL rm_after: got %0d/%h want 0/a0", oc1, od1); end
        v1 = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0; v0 = '0; v1 = '0; d0 = '0; d1 = '0;
        sel0 = '0; sel1 = '0; ordy0 = 1'b1; ordy1 = 1'b1;
        test_reset;
        test_sel;
        test_round_robin;
        test_wrap_skip;
        test_back_pressure;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
